// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter: NREQ requesters share one FIFO write port, up to MAX_BURST beats per grant.
// Optional per-requester accepted-beat counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DATA_W    = 128,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     fifo_wren,
  output logic [DATA_W-1:0]        fifo_wrdata,
  input  logic                     fifo_full,
  output logic [2:0]               grant_id,
  output logic                     busy,
  output logic [NREQ*16-1:0]       stat_cnt
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(MAX_BURST) + 1;

  // Handshake: a beat moves when req_valid[i] && req_ready[i] in the same cycle;
  // the FIFO is written on that same cycle (fifo_wren), with no extra latency.
  typedef enum logic {IDLE, BURST} state_t;

  state_t          state;
  logic [OW-1:0]   owner;
  logic [OW-1:0]   rr_ptr;
  logic [OW-1:0]   winner;
  logic [OW-1:0]   next_rr;
  logic [BW-1:0]   beat_cnt;
  logic            owner_valid;
  logic            accept;
  int              idx;

  // First valid requester scanning rr_ptr, rr_ptr+1, ... (wrapping); the lowest offset wins.
  always_comb begin
    winner = '0;
    idx    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req_valid[idx]) winner = OW'(idx);
    end
  end

  assign owner_valid = req_valid[owner];
  assign next_rr     = (owner == OW'(NREQ - 1)) ? '0 : owner + OW'(1);

  // Qualify with rstn so an edge that resets mid-burst never writes.
  assign accept = rstn && (state == BURST) && !fifo_full && owner_valid;

  always_comb begin
    req_ready = '0;
    if (rstn && (state == BURST) && !fifo_full) req_ready[owner] = 1'b1;
  end

  assign fifo_wren   = accept;
  assign fifo_wrdata = (state == BURST) ? req_data[int'(owner)*DATA_W +: DATA_W] : '0;
  assign grant_id    = 3'(owner);
  assign busy        = (state == BURST);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((|req_valid) && !fifo_full) begin
            owner    <= winner;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          // A full FIFO freezes the grant: owner, beat count and pointer all hold.
          if (!fifo_full) begin
            if (!owner_valid) begin
              state  <= IDLE;
              rr_ptr <= next_rr;
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
              if (beat_cnt == BW'(MAX_BURST - 1)) begin
                state  <= IDLE;
                rr_ptr <= next_rr;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stat_q [NREQ];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NREQ; i++) stat_q[i] <= '0;
    end else if (accept && (stat_q[owner] != 16'hFFFF)) begin
      stat_q[owner] <= stat_q[owner] + 16'd1;
    end
  end

  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < NREQ; i++) stat_cnt[i*16 +: 16] = stat_q[i];
  end
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a transaction-level model is compared against the DUT every cycle,
// and hand-written grant sequences pin the model for each scenario.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int MB   = 4;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*DW-1:0]   req_data = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 fifo_wren;
  logic [DW-1:0]        fifo_wrdata;
  logic                 fifo_full = 1'b0;
  logic [2:0]           grant_id;
  logic                 busy;
  logic [NREQ*16-1:0]   stat_cnt;

  fifo_wr_arbiter #(.NREQ(NREQ), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_wren(fifo_wren), .fifo_wrdata(fifo_wrdata),
    .fifo_full(fifo_full), .grant_id(grant_id), .busy(busy), .stat_cnt(stat_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [2:0] exp_q[$];
  logic [2:0] got_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_log(input string name);
    check({name, "_len"}, 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_w%0d", name, i), 128'(got_q[i]), 128'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- reference model ----------------
  // Grant-level view: who holds the port, how many beats remain, where the next search starts.
  bit m_burst = 0;
  int m_owner = 0;
  int m_rr = 0;
  int m_left = 0;
  int m_stat[NREQ];
  bit seen_edge = 0;

  initial for (int i = 0; i < NREQ; i++) m_stat[i] = 0;

  always @(posedge clk) begin
    seen_edge = 1;
    if (!rstn) begin
      m_burst = 0; m_owner = 0; m_rr = 0; m_left = 0;
      for (int i = 0; i < NREQ; i++) m_stat[i] = 0;
    end else if (!m_burst) begin
      if (req_valid != 0 && !fifo_full) begin
        for (int k = 0; k < NREQ; k++) begin
          if (req_valid[(m_rr + k) % NREQ]) begin
            m_owner = (m_rr + k) % NREQ;
            break;
          end
        end
        m_burst = 1;
        m_left = MB;
      end
    end else if (!fifo_full) begin
      if (!req_valid[m_owner]) begin
        m_burst = 0;
        m_rr = (m_owner + 1) % NREQ;
      end else begin
        if (m_stat[m_owner] < 65535) m_stat[m_owner]++;
        m_left--;
        if (m_left == 0) begin
          m_burst = 0;
          m_rr = (m_owner + 1) % NREQ;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [NREQ-1:0]    e_ready;
    logic               e_wren;
    logic [DW-1:0]      e_data;
    logic [NREQ*16-1:0] e_stat;
    if (seen_edge) begin
      e_ready = '0;
      if (rstn && m_burst && !fifo_full) e_ready[m_owner] = 1'b1;
      e_wren = (e_ready & req_valid) != 0;
      e_data = m_burst ? req_data[m_owner*DW +: DW] : '0;
      e_stat = '0;
`ifdef FIFO_ARB_STATS_EN
      for (int i = 0; i < NREQ; i++) e_stat[i*16 +: 16] = 16'(m_stat[i]);
`endif
      check("busy", 128'(busy), 128'(m_burst));
      check("req_ready", 128'(req_ready), 128'(e_ready));
      check("fifo_wren", 128'(fifo_wren), 128'(e_wren));
      check("fifo_wrdata", 128'(fifo_wrdata), 128'(e_data));
      check("grant_id", 128'(grant_id), 128'(m_owner));
      check("stat_cnt", 128'(stat_cnt), 128'(e_stat));
      if (fifo_wren) got_q.push_back(grant_id);
    end
  end

  // ---------------- drivers ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      req_data = {$urandom, $urandom, $urandom, $urandom};
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req_valid = '0;
    fifo_full = 1'b0;
    cyc(2);
    rstn = 1'b1;
    got_q.delete();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    // reset state
    cyc(3);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_ready", 128'(req_ready), 128'd0);
    check("rst_wren", 128'(fifo_wren), 128'd0);
    check("rst_gid", 128'(grant_id), 128'd0);
    check("rst_stat", 128'(stat_cnt), 128'd0);

    // single requester: bursts of 4 separated by one idle cycle
    do_reset();
    req_valid = 4'b0001;
    cyc(15);
    check("single_gid", 128'(grant_id), 128'd0);
    req_valid = '0;
    cyc(2);
    repeat (12) exp_q.push_back(3'd0);
    check_log("single");

    // all valid from reset: 0,1,2,3,0 with 4 beats each
    do_reset();
    req_valid = 4'b1111;
    cyc(22);
    for (int o = 0; o < 4; o++) repeat (4) exp_q.push_back(3'(o));
    exp_q.push_back(3'd0);
    check_log("rr_all");
`ifndef FIFO_ARB_STATS_EN
    check("stat_off_zero", 128'(stat_cnt), 128'd0);
`endif

    // full stall after beat 2
    do_reset();
    req_valid = 4'b0001;
    cyc(3);
    fifo_full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      check($sformatf("stall_ready_%0d", s), 128'(req_ready), 128'd0);
      check($sformatf("stall_wren_%0d", s), 128'(fifo_wren), 128'd0);
      check($sformatf("stall_busy_%0d", s), 128'(busy), 128'd1);
      check($sformatf("stall_gid_%0d", s), 128'(grant_id), 128'd0);
      cyc(1);
    end
    fifo_full = 1'b0;
    cyc(2);
    req_valid = '0;
    cyc(2);
    repeat (4) exp_q.push_back(3'd0);
    check_log("stall");

    // early release: owner 2 drops after one beat while 3 waits
    do_reset();
    req_valid = 4'b0010;
    cyc(2);
    req_valid = '0;
    cyc(1);
    req_valid = 4'b1100;
    cyc(2);
    req_valid = 4'b1000;
    cyc(1);
    check("early_idle", 128'(busy), 128'd0);
    req_valid = 4'b1100;
    cyc(3);
    check("early_gid", 128'(grant_id), 128'd3);
    req_valid = '0;
    cyc(2);
    exp_q.push_back(3'd1); exp_q.push_back(3'd2);
    exp_q.push_back(3'd3); exp_q.push_back(3'd3);
    check_log("early");

    // reset in beat 2 of owner 1, with rr_ptr previously moved to 3
    do_reset();
    req_valid = 4'b0100;
    cyc(2);
    req_valid = '0;
    cyc(1);
    req_valid = 4'b0010;
    cyc(2);
    rstn = 1'b0;
    #1;
    check("midrst_wren", 128'(fifo_wren), 128'd0);
    check("midrst_ready", 128'(req_ready), 128'd0);
    cyc(1);
    check("postrst_busy", 128'(busy), 128'd0);
    check("postrst_ready", 128'(req_ready), 128'd0);
    check("postrst_gid", 128'(grant_id), 128'd0);
    check("postrst_stat", 128'(stat_cnt), 128'd0);
    rstn = 1'b1;
    req_valid = 4'b1010;
    cyc(2);
    check("postrst_owner", 128'(grant_id), 128'd1);
    req_valid = '0;
    cyc(2);
    exp_q.push_back(3'd2); exp_q.push_back(3'd1); exp_q.push_back(3'd1);
    check_log("midrst");

`ifdef FIFO_ARB_STATS_EN
    // saturation: 66000 beats from requester 0
    do_reset();
    req_valid = 4'b0001;
    cyc(82500);
    check("stat_sat", 128'(stat_cnt[15:0]), 128'h0000_FFFF);
    check("stat_others", 128'(stat_cnt[NREQ*16-1:16]), 128'd0);
    req_valid = '0;
    cyc(2);
    got_q.delete();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
